// File: rtl/bnn_output_packer.sv
// Packs single-bit neuron decisions into WORD_W-bit words and queues them in a
// DEPTH-entry FIFO drained over valid/ready.
module bnn_output_packer #(
   parameter int WORD_W    = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       bit_in,
   input  logic                       bit_valid,
   input  logic                       flush,
   output logic [WORD_W-1:0]          word_out,
   output logic                       word_valid,
   input  logic                       word_ready,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [$clog2(WORD_W)-1:0]  bit_idx,
   output logic                       overflow
);

   localparam int IW = $clog2(WORD_W);
   localparam int LW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

   state_t            state, state_nxt;
   logic [WORD_W-1:0] pack, pack_nxt;
   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [IW-1:0]     pos;
   logic [LW-1:0]     level_nxt;
   logic              complete, push, pop, accept;

   always_comb pos = (MSB_FIRST != 0) ? IW'(WORD_W-1) - bit_idx : bit_idx;

   // pack_nxt already includes this edge's bit, so completion and flush push it
   always_comb begin
      pack_nxt = pack;
      if (bit_valid) pack_nxt[pos] = bit_in;
   end

   assign complete = bit_valid && (bit_idx == IW'(WORD_W-1));
   assign push     = complete || (flush && (bit_idx != '0 || bit_valid));
   assign pop      = word_valid && word_ready;
   assign accept   = push && ((level != LW'(DEPTH)) || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack     <= '0;
         bit_idx  <= '0;
         overflow <= 1'b0;
      end else if (push) begin
         pack    <= '0;
         bit_idx <= '0;
         if (!accept) overflow <= 1'b1;
      end else if (bit_valid) begin
         pack    <= pack_nxt;
         bit_idx <= bit_idx + IW'(1);
      end
   end

   // When full with a simultaneous pop, wr_ptr==rd_ptr: the new word lands in
   // the slot being vacated, which becomes the tail.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= pack_nxt;
   end

   always_comb begin
      level_nxt = level;
      if (accept && !pop)      level_nxt = level + LW'(1);
      else if (pop && !accept) level_nxt = level - LW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = PARTIAL;
      if (level_nxt == '0)               state_nxt = EMPTY;
      else if (level_nxt == LW'(DEPTH))  state_nxt = FULL;
   end

   always_comb begin
      word_valid = (state != EMPTY);
      word_out   = word_valid ? mem[rd_ptr] : '0;
   end

endmodule

// File: tb/tb_bnn_output_packer.sv
// Randomized + directed bench for bnn_output_packer: bit-list reference model,
// expected words queued in a scoreboard and checked by a negedge monitor.
module tb_bnn_output_packer;

   localparam int WORD_W    = 8;
   localparam int DEPTH     = 4;
   localparam int MSB_FIRST = 0;

   logic                       clk = 0;
   logic                       rst_n;
   logic                       bit_in, bit_valid, flush, word_ready;
   logic [WORD_W-1:0]          word_out;
   logic                       word_valid;
   logic [$clog2(DEPTH+1)-1:0] level;
   logic [$clog2(WORD_W)-1:0]  bit_idx;
   logic                       overflow;

   bnn_output_packer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .MSB_FIRST(MSB_FIRST)) dut (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
      .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
      .level(level), .bit_idx(bit_idx), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model state
   bit m_bits[$];
   int exp_q[$];
   int m_level = 0;
   bit m_ovf = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: DUT state vs model, and popped words vs scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         chk("word_valid", int'(word_valid), int'(m_level > 0));
         chk("level", int'(level), m_level);
         chk("bit_idx", int'(bit_idx), m_bits.size());
         chk("overflow", int'(overflow), int'(m_ovf));
         if (word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", int'(word_out), -1);
            end else begin
               chk("word_out", int'(word_out), exp_q.pop_front());
            end
         end
      end
   end

   // one clock edge: drive inputs, then advance the model with what the edge saw
   task automatic step(input bit bv, input bit bi, input bit fl, input bit rdy);
      bit pop;
      int w;
      bit_valid  = bv;
      bit_in     = bi;
      flush      = fl;
      word_ready = rdy;
      @(posedge clk);
      pop = (m_level > 0) && rdy;
      if (bv) m_bits.push_back(bi);
      if (m_bits.size() == WORD_W || (fl && m_bits.size() > 0)) begin
         w = 0;
         for (int i = 0; i < m_bits.size(); i++)
            if (m_bits[i]) w += (MSB_FIRST != 0) ? (1 << (WORD_W-1-i)) : (1 << i);
         m_bits.delete();
         if (m_level < DEPTH || pop) begin
            exp_q.push_back(w);
            m_level++;
         end else begin
            m_ovf = 1;
         end
      end
      if (pop) m_level--;
      #1;
   endtask

   task automatic send_word(input int w, input bit rdy_last);
      for (int i = 0; i < WORD_W; i++) step(1, w[i], 0, (i == WORD_W-1) ? rdy_last : 1'b0);
   endtask

   task automatic drain(input int n);
      repeat (n) step(0, 0, 0, 1);
   endtask

   task automatic do_reset();
      bit_valid = 0; bit_in = 0; flush = 0; word_ready = 0;
      #2 rst_n = 0;
      #1;
      chk("rst_word_valid", int'(word_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_bit_idx", int'(bit_idx), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_word_out", int'(word_out), 0);
      m_bits.delete();
      exp_q.delete();
      m_level = 0;
      m_ovf = 0;
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] seq;
      rst_n = 0; bit_in = 0; bit_valid = 0; flush = 0; word_ready = 0;
      #2;
      chk("init_word_valid", int'(word_valid), 0);
      chk("init_word_out", int'(word_out), 0);
      chk("init_level", int'(level), 0);
      chk("init_overflow", int'(overflow), 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;

      // bits 1,0,1,1,0,0,1,0 -> 0x4D
      seq = 8'b0100_1101;
      for (int i = 0; i < 8; i++) step(1, seq[i], 0, 0);
      chk("word_4D", int'(word_out), 8'h4D);
      chk("level_1", int'(level), 1);
      chk("bit_idx_0", int'(bit_idx), 0);
      drain(2);

      // 3 ones then a lone flush -> 0x07; second flush is a no-op
      repeat (3) step(1, 1, 0, 0);
      step(0, 0, 1, 0);
      chk("word_07", int'(word_out), 8'h07);
      step(0, 0, 1, 0);
      chk("flush_noop_level", int'(level), 1);
      drain(2);

      // overflow: five words with no drain
      for (int w = 1; w <= 5; w++) send_word(w, 0);
      chk("ovf_level", int'(level), 4);
      chk("ovf_flag", int'(overflow), 1);
      drain(6);
      chk("ovf_drained", int'(word_valid), 0);
      do_reset();

      // full with a pop on the completing edge: no overflow
      for (int w = 1; w <= 4; w++) send_word(w, 0);
      send_word(5, 1);
      chk("full_pop_level", int'(level), 4);
      chk("full_pop_ovf", int'(overflow), 0);
      chk("full_pop_head", int'(word_out), 2);
      drain(6);

      // 7 bits then bit_valid with flush: one word
      for (int i = 0; i < 7; i++) step(1, i[0], 0, 0);
      step(1, 1, 1, 0);
      chk("flush_complete_level", int'(level), 1);
      chk("flush_complete_idx", int'(bit_idx), 0);
      drain(2);

      // reset mid-word with two words stored, then a fresh word
      send_word(8'h3C, 0);
      send_word(8'hC3, 0);
      repeat (3) step(1, 1, 0, 0);
      do_reset();
      send_word(8'hA5, 0);
      chk("post_reset_word", int'(word_out), 8'hA5);
      drain(2);

      // random traffic
      for (int c = 0; c < 600; c++)
         step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
              $urandom_range(0, 1) == 1);
      drain(DEPTH + 2);
      chk("sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
